// File: rtl/mist1032isa_uart_receiver.sv
// MIST1032ISA UART receiver: 8N1, LSB first, x4 oversampling tick used as a clock enable on iCLOCK.
// state | meaning: IDLE wait for start edge; START mid-start check; DATA shift 8 bits; STOP stop sample; BREAK wait for line high.
module mist1032isa_uart_receiver #(
  parameter bit          BAUDRATE_FIXED   = 1'b1,
  parameter logic [19:0] BAUDRATE_COUNTER = 20'd108
)(
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic [19:0] iEXTBAUD_COUNT,
  input  logic        iUART_RXD,
  output logic        oRX_VALID,
  output logic [7:0]  oRX_DATA,
  input  logic        iRX_ACK,
  output logic        oRX_FRAME_ERR,
  output logic        oRX_OVERRUN,
  output logic        oRX_BUSY
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state;
  logic        rxd_m, rxd_s, rxd_prev;
  logic [19:0] baud_cnt;
  logic [19:0] divisor;
  logic        tick;
  logic        fall;
  logic [1:0]  sub_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;

  assign divisor = BAUDRATE_FIXED ? BAUDRATE_COUNTER : iEXTBAUD_COUNT;
  // >= so a divisor lowered mid-frame cannot strand the counter above the compare value
  assign tick    = (state != IDLE) && (baud_cnt >= divisor);
  assign fall    = rxd_prev & ~rxd_s;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      rxd_m    <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_m    <= iUART_RXD;
      rxd_s    <= rxd_m;
      rxd_prev <= rxd_s;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET)              baud_cnt <= 20'd0;
    else if (state == IDLE)  baud_cnt <= 20'd0;
    else if (tick)           baud_cnt <= 20'd0;
    else                     baud_cnt <= baud_cnt + 20'd1;
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state         <= IDLE;
      sub_cnt       <= 2'd0;
      bit_idx       <= 3'd0;
      shift         <= 8'h00;
      oRX_VALID     <= 1'b0;
      oRX_DATA      <= 8'h00;
      oRX_FRAME_ERR <= 1'b0;
      oRX_OVERRUN   <= 1'b0;
      oRX_BUSY      <= 1'b0;
    end else begin
      oRX_FRAME_ERR <= 1'b0;
      oRX_OVERRUN   <= 1'b0;
      if (iRX_ACK && oRX_VALID) oRX_VALID <= 1'b0;
      case (state)
        IDLE: begin
          sub_cnt <= 2'd0;
          if (fall) begin
            state    <= START;
            oRX_BUSY <= 1'b1;
          end
        end
        START: if (tick) begin
          if (sub_cnt == 2'd1) begin
            sub_cnt <= 2'd0;
            bit_idx <= 3'd0;
            if (!rxd_s) begin
              state <= DATA;
            end else begin
              state    <= IDLE;
              oRX_BUSY <= 1'b0;
            end
          end else begin
            sub_cnt <= sub_cnt + 2'd1;
          end
        end
        DATA: if (tick) begin
          sub_cnt <= sub_cnt + 2'd1;
          if (sub_cnt == 2'd3) begin
            shift <= {rxd_s, shift[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: if (tick) begin
          sub_cnt <= sub_cnt + 2'd1;
          if (sub_cnt == 2'd3) begin
            if (rxd_s) begin
              // an ACK in the same cycle frees the slot, so the new byte wins over overrun
              if (!oRX_VALID || iRX_ACK) begin
                oRX_DATA  <= shift;
                oRX_VALID <= 1'b1;
              end else begin
                oRX_OVERRUN <= 1'b1;
              end
              state    <= IDLE;
              oRX_BUSY <= 1'b0;
            end else begin
              oRX_FRAME_ERR <= 1'b1;
              state         <= BREAK;
            end
          end
        end
        BREAK: if (rxd_s) begin
          state    <= IDLE;
          oRX_BUSY <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          oRX_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule
